// File: rtl/fsm_sequencer_pkg.sv
// Purpose: shared encodings for the multicycle RISC next-state sequencer.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
// Contents: state_t (fixed state_id encoding), opcode constants, cz codes,
//           is_mem_state() helper.
package fsm_seq_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_RR_EX    = 5'd1,
    S_RR_WB    = 5'd2,
    S_ADI_EX   = 5'd3,
    S_ADI_WB   = 5'd4,
    S_LHI_WB   = 5'd5,
    S_JAL      = 5'd6,
    S_CZ_SKIP  = 5'd7,
    S_NDU_EX   = 5'd8,
    S_NDU_WB   = 5'd9,
    S_MEM_ADDR = 5'd10,
    S_LW_RD    = 5'd11,
    S_LW_WB    = 5'd12,
    S_SW_WR    = 5'd13,
    S_LM_RD    = 5'd14,
    S_SM_WR    = 5'd15,
    S_BEQ_CMP  = 5'd16,
    S_BEQ_TAKE = 5'd17,
    S_JLR      = 5'd18,
    S_DECODE   = 5'd19,
    S_ILLEGAL  = 5'd20,
    S_RESET    = 5'd31
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // ir[1:0] condition field of ADD/NDU
  localparam logic [1:0] CZ_ALWAYS = 2'b00;
  localparam logic [1:0] CZ_ZERO   = 2'b01;
  localparam logic [1:0] CZ_CARRY  = 2'b10;
  localparam logic [1:0] CZ_BAD    = 2'b11;

  // States that own the memory port and hold until mem_ack
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LW_RD) || (s == S_SW_WR) ||
           (s == S_LM_RD) || (s == S_SM_WR);
  endfunction

endpackage

// File: rtl/fsm_sequencer_if.sv
// Purpose: datapath <-> sequencer control bundle.
// Latency: n/a (wires only).
// Backpressure: memory side stalls the sequencer through mem_ack.
// Ports: master = sequencer (drives state_id and strobes), slave = datapath/memory.
interface fsm_sequencer_if #(parameter int ST_W = 5);
  logic [15:0]     ir;
  logic            c_flag;
  logic            z_flag;
  logic            alu_eq;
  logic            mem_ack;
  logic [ST_W-1:0] state_id;
  logic            mem_req;
  logic            mem_we;
  logic            ir_wen;
  logic            pc_wen;
  logic            addr_inc;
  logic [2:0]      reg_sel;
  logic            instr_done;
  logic            illegal;
  logic            mem_timeout;

  modport master (
    input  ir, c_flag, z_flag, alu_eq, mem_ack,
    output state_id, mem_req, mem_we, ir_wen, pc_wen, addr_inc, reg_sel,
           instr_done, illegal, mem_timeout
  );

  modport slave (
    output ir, c_flag, z_flag, alu_eq, mem_ack,
    input  state_id, mem_req, mem_we, ir_wen, pc_wen, addr_inc, reg_sel,
           instr_done, illegal, mem_timeout
  );
endinterface

// File: rtl/fsm_sequencer_lsb_index_enc.sv
// Purpose: index of the lowest set bit of an 8-bit vector, plus any-set flag.
// Latency: combinational.
// Backpressure: none.
// Ports: vec in 8, idx out 3 (0 when vec==0), any out 1.
module lsb_index_enc (
  input  logic [7:0] vec,
  output logic [2:0] idx,
  output logic       any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downward so the lowest set bit is the last one written
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/fsm_sequencer.sv
// Purpose: next-state sequencer for the multicycle 16-bit RISC datapath.
// Latency: one state per cycle; memory states hold until mem_ack.
// Backpressure: mem_ack low stalls; a stall counter raises sticky mem_timeout.
// Ports: clk, rst_n (async active-low), bus (fsm_sequencer_if.master).
module fsm_sequencer
  import fsm_seq_pkg::*;
#(
  parameter int ST_W         = 5,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  fsm_sequencer_if.master   bus
);

  localparam int              CNT_W     = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [7:0]       mask_q, mask_d;
  logic [CNT_W-1:0] wait_q;
  logic             timeout_q;
  logic             done_q;

  logic [3:0] opcode;
  logic [1:0] cz;
  logic       cz_pass;
  logic [7:0] enc_in;
  logic [2:0] enc_idx;
  logic       enc_any;
  logic [7:0] mask_rest;
  logic       stall;

  assign opcode = bus.ir[15:12];
  assign cz     = bus.ir[1:0];
  assign cz_pass = (cz == CZ_ALWAYS) ||
                   (cz == CZ_CARRY && bus.c_flag) ||
                   (cz == CZ_ZERO  && bus.z_flag);

  // In MEM_ADDR the encoder looks at the fresh list (empty test);
  // afterwards it tracks the remaining mask (reg_sel).
  assign enc_in    = (state_q == S_MEM_ADDR) ? bus.ir[7:0] : mask_q;
  assign mask_rest = mask_q & (mask_q - 8'd1);
  assign stall     = is_mem_state(state_q) && !bus.mem_ack;

  lsb_index_enc u_enc (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      mask_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      done_q  <= (state_d == S_FETCH) && (state_q != S_FETCH) &&
                 (state_q != S_RESET);
      if (stall) begin
        if (wait_q != WAIT_MAX) wait_q <= wait_q + 1'b1;
        if (wait_q == WAIT_LAST) timeout_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.ir_wen   = 1'b0;
    bus.pc_wen   = 1'b0;
    bus.addr_inc = 1'b0;
    bus.reg_sel  = '0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          bus.ir_wen = 1'b1;
          bus.pc_wen = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD: state_d = (cz == CZ_BAD) ? S_ILLEGAL :
                            (cz_pass ? S_RR_EX : S_CZ_SKIP);
          OP_NDU: state_d = (cz == CZ_BAD) ? S_ILLEGAL :
                            (cz_pass ? S_NDU_EX : S_CZ_SKIP);
          OP_ADI: state_d = S_ADI_EX;
          OP_LHI: state_d = S_LHI_WB;
          OP_LW, OP_SW, OP_LM, OP_SM: state_d = S_MEM_ADDR;
          OP_BEQ: state_d = S_BEQ_CMP;
          OP_JAL: state_d = S_JAL;
          OP_JLR: state_d = S_JLR;
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_RR_EX:   state_d = S_RR_WB;
      S_ADI_EX:  state_d = S_ADI_WB;
      S_NDU_EX:  state_d = S_NDU_WB;
      S_RR_WB, S_ADI_WB, S_NDU_WB, S_LHI_WB, S_CZ_SKIP, S_LW_WB:
        state_d = S_FETCH;
      S_BEQ_CMP: state_d = bus.alu_eq ? S_BEQ_TAKE : S_FETCH;
      S_BEQ_TAKE, S_JAL, S_JLR: begin
        bus.pc_wen = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        case (opcode)
          OP_LW: state_d = S_LW_RD;
          OP_SW: state_d = S_SW_WR;
          OP_LM, OP_SM: begin
            mask_d = bus.ir[7:0];
            if (!enc_any)              state_d = S_FETCH;
            else if (opcode == OP_LM)  state_d = S_LM_RD;
            else                       state_d = S_SM_WR;
          end
          default: state_d = S_ILLEGAL;
        endcase
      end
      S_LW_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_d = S_LW_WB;
      end
      S_SW_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) state_d = S_FETCH;
      end
      S_LM_RD, S_SM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = (state_q == S_SM_WR);
        bus.reg_sel = enc_idx;
        if (bus.mem_ack) begin
          bus.addr_inc = 1'b1;
          mask_d       = mask_rest;
          if (mask_rest == 8'd0) state_d = S_FETCH;
        end
      end
      S_ILLEGAL: state_d = S_ILLEGAL;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  assign bus.state_id    = ST_W'(state_q);
  assign bus.instr_done  = done_q;
  assign bus.illegal     = (state_q == S_ILLEGAL);
  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Purpose: directed self-checking bench for fsm_sequencer.
// Latency: inputs driven 1-2 ns after posedge, outputs sampled before next edge.
// Backpressure: mem_ack is driven directly by the stimulus.
module tb_fsm_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fsm_sequencer_if #(.ST_W(5)) bus ();

  fsm_sequencer #(.ST_W(5), .MEM_WAIT_MAX(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input int exp);
    @(posedge clk);
    #2;
    chk(tag, 32'(bus.state_id), exp);
  endtask

  // Called in FETCH: acks the fetch with instruction v and lands in DECODE.
  task automatic do_fetch(input string tag, input logic [15:0] v);
    bus.ir      = v;
    bus.mem_ack = 1'b1;
    #1;
    chk({tag, "_fetch_st"}, 32'(bus.state_id), 0);
    chk({tag, "_ir_wen"}, 32'(bus.ir_wen), 1);
    chk({tag, "_pc_wen"}, 32'(bus.pc_wen), 1);
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    #1;
    chk({tag, "_decode"}, 32'(bus.state_id), 19);
  endtask

  initial begin
    bus.ir = '0; bus.c_flag = 0; bus.z_flag = 0; bus.alu_eq = 0; bus.mem_ack = 0;
    #12;
    chk("rst_state", 32'(bus.state_id), 31);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_ir_wen", 32'(bus.ir_wen), 0);
    chk("rst_pc_wen", 32'(bus.pc_wen), 0);
    chk("rst_done", 32'(bus.instr_done), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_timeout", 32'(bus.mem_timeout), 0);
    chk("rst_reg_sel", 32'(bus.reg_sel), 0);

    // Reset then ADD with a 2-cycle fetch stall
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_state", 32'(bus.state_id), 31);
    step("fetch0", 0);
    chk("fetch0_req", 32'(bus.mem_req), 1);
    chk("fetch0_ir_wen", 32'(bus.ir_wen), 0);
    chk("fetch0_done", 32'(bus.instr_done), 0);
    step("fetch1", 0);
    chk("fetch1_pc_wen", 32'(bus.pc_wen), 0);
    step("fetch2", 0);
    do_fetch("add", 16'h0000);
    chk("add_dec_ir_wen", 32'(bus.ir_wen), 0);
    step("add_rr_ex", 1);
    step("add_rr_wb", 2);
    step("add_ret", 0);
    chk("add_done", 32'(bus.instr_done), 1);
    step("add_hold", 0);
    chk("add_done_once", 32'(bus.instr_done), 0);

    // ADC with carry clear skips; ADZ with zero set executes
    bus.c_flag = 0;
    do_fetch("adc", 16'h0002);
    step("adc_skip", 7);
    step("adc_ret", 0);
    chk("adc_done", 32'(bus.instr_done), 1);
    bus.z_flag = 1;
    do_fetch("adz", 16'h0001);
    step("adz_rr_ex", 1);
    step("adz_rr_wb", 2);
    step("adz_ret", 0);
    bus.z_flag = 0;

    // LM list 0xA4: registers 2, 5, 7
    do_fetch("lm", 16'h60A4);
    step("lm_addr", 10);
    chk("lm_addr_req", 32'(bus.mem_req), 0);
    step("lm_rd", 14);
    chk("lm_req", 32'(bus.mem_req), 1);
    chk("lm_we", 32'(bus.mem_we), 0);
    chk("lm_sel_stall", 32'(bus.reg_sel), 2);
    chk("lm_inc_stall", 32'(bus.addr_inc), 0);
    bus.mem_ack = 1'b1; #1;
    chk("lm_sel_a", 32'(bus.reg_sel), 2);
    chk("lm_inc_a", 32'(bus.addr_inc), 1);
    step("lm_rd_b", 14);
    chk("lm_sel_b", 32'(bus.reg_sel), 5);
    chk("lm_inc_b", 32'(bus.addr_inc), 1);
    step("lm_rd_c", 14);
    chk("lm_sel_c", 32'(bus.reg_sel), 7);
    chk("lm_inc_c", 32'(bus.addr_inc), 1);
    step("lm_ret", 0);
    bus.mem_ack = 1'b0; #1;
    chk("lm_done", 32'(bus.instr_done), 1);
    chk("lm_ret_inc", 32'(bus.addr_inc), 0);

    // LM with empty list
    do_fetch("lm0", 16'h6000);
    step("lm0_addr", 10);
    chk("lm0_req", 32'(bus.mem_req), 0);
    step("lm0_ret", 0);
    chk("lm0_done", 32'(bus.instr_done), 1);

    // BEQ taken, BEQ not taken, JAL
    bus.alu_eq = 1;
    do_fetch("beq_t", 16'hC000);
    step("beq_t_cmp", 16);
    chk("beq_t_cmp_pc", 32'(bus.pc_wen), 0);
    step("beq_t_take", 17);
    chk("beq_t_pc", 32'(bus.pc_wen), 1);
    step("beq_t_ret", 0);
    bus.alu_eq = 0;
    do_fetch("beq_n", 16'hC000);
    step("beq_n_cmp", 16);
    step("beq_n_ret", 0);
    chk("beq_n_done", 32'(bus.instr_done), 1);
    do_fetch("jal", 16'h8000);
    step("jal_st", 6);
    chk("jal_pc", 32'(bus.pc_wen), 1);
    step("jal_ret", 0);

    // SW with a 16-cycle stall
    do_fetch("sw", 16'h5000);
    step("sw_addr", 10);
    step("sw_wr", 13);
    chk("sw_req", 32'(bus.mem_req), 1);
    chk("sw_we", 32'(bus.mem_we), 1);
    chk("sw_to0", 32'(bus.mem_timeout), 0);
    for (int i = 1; i <= 16; i++) begin
      step($sformatf("sw_hold%0d", i), 13);
      chk($sformatf("sw_to%0d", i), 32'(bus.mem_timeout), (i >= 15) ? 1 : 0);
    end
    bus.mem_ack = 1'b1; #1;
    chk("sw_ack_st", 32'(bus.state_id), 13);
    step("sw_ret", 0);
    bus.mem_ack = 1'b0; #1;
    chk("sw_to_sticky", 32'(bus.mem_timeout), 1);

    // Reset pulse in the middle of a stalled store
    do_fetch("swr", 16'h5000);
    step("swr_addr", 10);
    step("swr_wr", 13);
    step("swr_hold", 13);
    #2; rst_n = 1'b0; #1;
    chk("swr_rst_st", 32'(bus.state_id), 31);
    chk("swr_rst_to", 32'(bus.mem_timeout), 0);
    chk("swr_rst_req", 32'(bus.mem_req), 0);
    chk("swr_rst_we", 32'(bus.mem_we), 0);
    #2; rst_n = 1'b1;
    step("swr_fetch", 0);
    chk("swr_fetch_done", 32'(bus.instr_done), 0);

    // Illegal opcode is absorbing and silent even with mem_ack high
    do_fetch("ill", 16'hF000);
    step("ill_st", 20);
    chk("ill_flag", 32'(bus.illegal), 1);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step($sformatf("ill_hold%0d", i), 20);
      chk($sformatf("ill_req%0d", i), 32'(bus.mem_req), 0);
      chk($sformatf("ill_pc%0d", i), 32'(bus.pc_wen), 0);
    end
    bus.mem_ack = 1'b0;
    rst_n = 1'b0; #1;
    chk("ill_rst_st", 32'(bus.state_id), 31);
    chk("ill_rst_flag", 32'(bus.illegal), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
